// File: rtl/seg7_pkg.sv
// Shared constants, digit-index map and helper for the seven-segment scan driver.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDX_TIME_TENS  = 2'd3;
    localparam logic [1:0] IDX_TIME_ONES  = 2'd2;
    localparam logic [1:0] IDX_SCORE_TENS = 2'd1;
    localparam logic [1:0] IDX_SCORE_ONES = 2'd0;

    typedef struct packed {
        logic [3:0] time_tens;
        logic [3:0] time_ones;
        logic [3:0] score_tens;
        logic [3:0] score_ones;
    } digits_t;

    function automatic int dwell_cycles(input int clock_freq, input int refresh_hz);
        return clock_freq / refresh_hz;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decode with a blank override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode display driver with per-frame snapshot,
// leading-zero blanking and a dark guard cycle per digit. Optional blink on time 00: SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] time_tens,
    input  logic [3:0] time_ones,
    input  logic [3:0] score_tens,
    input  logic [3:0] score_ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int             DWELL    = dwell_cycles(CLOCK_FREQ, REFRESH_HZ);
    localparam int             CW       = $clog2(DWELL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);

    if (DWELL < 2 || BLINK_FRAMES < 1) begin : g_cfg_err
        $error("seg7_scan_driver: DWELL must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    digits_t       snap;
    digits_t       live;
    logic          frame_end;
    logic          blink_on;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [6:0]    seg_d;

    assign live      = {time_tens, time_ones, score_tens, score_ones};
    assign frame_end = (idx == IDX_SCORE_ONES) && (cnt == CNT_LAST);

    // Scan state; the 2-bit index wraps 0 -> 3 by itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= IDX_TIME_TENS;
            snap <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx - 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_end) snap <= live;
        end
    end

    always_comb begin
        cur_digit = snap.score_ones;
        cur_blank = 1'b0;
        case (idx)
            IDX_TIME_TENS: begin
                cur_digit = snap.time_tens;
                cur_blank = (snap.time_tens == 4'd0);
            end
            IDX_TIME_ONES:  cur_digit = snap.time_ones;
            IDX_SCORE_TENS: begin
                cur_digit = snap.score_tens;
                cur_blank = (snap.score_tens == 4'd0);
            end
            default:        cur_digit = snap.score_ones;
        endcase
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_d)
    );

`ifdef SEG7_BLINK_EN
    localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;

    // Judged on the value being latched, so the phase always matches the frame it governs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (en && frame_end) begin
            if (live.time_tens == 4'd0 && live.time_ones == 4'd0) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end
        end
    end
`else
    assign blink_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= (en && blink_on && cnt != '0) ? ~(4'b0001 << idx) : 4'b1111;
            seg        <= seg_d;
            dp         <= (idx != IDX_TIME_ONES);
            frame_done <= en && frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DWELL=4, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] time_tens, time_ones, score_tens, score_ones;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]      tt;
        logic [3:0]      to;
        logic [3:0]      st;
        logic [3:0]      so;
        logic [3:0][6:0] exp;   // exp[3] = leftmost digit
    } vec_t;

    vec_t vecs [6];
    vec_t zv;
    vec_t tv;

    seg7_scan_driver #(
        .CLOCK_FREQ   (8),
        .REFRESH_HZ   (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .time_tens  (time_tens),
        .time_ones  (time_ones),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        time_tens  = v.tt;
        time_ones  = v.to;
        score_tens = v.st;
        score_ones = v.so;
    endtask

    // Called right after a frame boundary sample; walks 16 cycles of one frame.
    // New inputs are driven mid-frame and must not show until the following frame.
    task automatic check_frame(input logic [3:0][6:0] exp, input vec_t nxt, input bit lit, input string tag);
        int d, pos;
        logic [3:0] exp_an;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            d      = 3 - (j - 1) / 4;
            pos    = (j - 1) % 4;
            exp_an = (pos == 0 || !lit) ? 4'b1111 : ~(4'b0001 << d);
            chk($sformatf("%s an c%0d", tag, j), 32'(an), 32'(exp_an));
            chk($sformatf("%s seg c%0d", tag, j), 32'(seg), 32'(exp[d]));
            chk($sformatf("%s dp c%0d", tag, j), 32'(dp), (d == 2) ? 32'd0 : 32'd1);
            chk($sformatf("%s frame_done c%0d", tag, j), 32'(frame_done), (j == 16) ? 32'd1 : 32'd0);
            if (j == 6) apply(nxt);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " an"}, 32'(an), 32'hF);
        chk({tag, " seg"}, 32'(seg), 32'h7F);
        chk({tag, " dp"}, 32'(dp), 32'd1);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        logic [3:0] en_an [10];

        zv      = '{4'd0, 4'd0, 4'd0, 4'd0, {7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000}};
        vecs[0] = '{4'd4, 4'd5, 4'd0, 4'd7, {7'b0011001, 7'b0010010, 7'b1111111, 7'b1111000}};
        vecs[1] = '{4'd4, 4'd4, 4'd0, 4'd7, {7'b0011001, 7'b0011001, 7'b1111111, 7'b1111000}};
        vecs[2] = '{4'd1, 4'd0, 4'd1, 4'd2, {7'b1111001, 7'b1000000, 7'b1111001, 7'b0100100}};
        vecs[3] = '{4'd0, 4'd9, 4'd12, 4'd3, {7'b1111111, 7'b0010000, 7'b0111111, 7'b0110000}};
        vecs[4] = '{4'd9, 4'd8, 4'd6, 4'd0, {7'b0010000, 7'b0000000, 7'b0000010, 7'b1000000}};
        vecs[5] = '{4'd15, 4'd0, 4'd0, 4'd0, {7'b0111111, 7'b1000000, 7'b1111111, 7'b1000000}};
        tv      = '{4'd1, 4'd0, 4'd0, 4'd0, {7'b1111001, 7'b1000000, 7'b1111111, 7'b1000000}};
        // an after resuming from an en-low hold at index 2, counter 2
        en_an = '{4'b1011, 4'b1011, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
                  4'b1111, 4'b1110, 4'b1110, 4'b1110};

        rst_n = 1'b0;
        en    = 1'b1;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // First frame shows the zero snapshot, then each vector one frame after its latch
        check_frame(zv.exp, vecs[0], 1'b1, "frame0");
        for (int i = 1; i < 6; i++)
            check_frame(vecs[i-1].exp, vecs[i], 1'b1, $sformatf("vec%0d", i - 1));
        check_frame(vecs[5].exp, vecs[5], 1'b1, "vec5");

        // en low for 10 cycles while index 2 is mid-dwell
        repeat (6) @(negedge clk);
        chk("pre_en an", 32'(an), 32'hB);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("en_low an %0d", k), 32'(an), 32'hF);
            chk($sformatf("en_low frame_done %0d", k), 32'(frame_done), 32'd0);
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("resume an %0d", k), 32'(an), 32'(en_an[k]));
            chk($sformatf("resume frame_done %0d", k), 32'(frame_done), (k == 9) ? 32'd1 : 32'd0);
        end

        // Reset mid-frame while en is low
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        apply(zv);
        @(negedge clk);
        check_reset("mid_reset");
        rst_n = 1'b1;
        en    = 1'b1;
        check_frame(zv.exp, zv, 1'b1, "rst_frame1");

`ifdef SEG7_BLINK_EN
        check_frame(zv.exp, zv, 1'b1, "blink_f2");
        check_frame(zv.exp, zv, 1'b0, "blink_f3");
        check_frame(zv.exp, zv, 1'b0, "blink_f4");
        check_frame(zv.exp, zv, 1'b1, "blink_f5");
        check_frame(zv.exp, tv, 1'b1, "blink_f6");
        check_frame(tv.exp, tv, 1'b1, "blink_f7");
        check_frame(tv.exp, tv, 1'b1, "blink_f8");
`else
        check_frame(zv.exp, zv, 1'b1, "steady_f2");
        check_frame(zv.exp, zv, 1'b1, "steady_f3");
        check_frame(zv.exp, zv, 1'b1, "steady_f4");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed four-digit seven-segment display driver for the whack-a-mole board. It consumes the BCD time digits from the game countdown timer and the BCD score digits, and scans them onto a common-anode display. It latches a tear-free snapshot once per frame, blanks leading zeros and inserts a one-cycle ghosting guard at every digit switch. It can optionally flash the display when time reaches 00.

## Interface
- CLOCK_FREQ, 50000000, system clock in Hz
- REFRESH_HZ, 1000, digit-switch rate; DWELL = CLOCK_FREQ/REFRESH_HZ cycles per digit, must be ≥ 2
- BLINK_FRAMES, 125, frames per blink half-period (only used with BLINK_EN)
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  display enable; 0 blanks all anodes and holds all counters
- time_tens, time_ones  in  4 each  BCD game time from the timer
- score_tens, score_ones  in  4 each  BCD score
- an  out  4  anode selects, active-low; an[3] leftmost
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse per completed four-digit frame

## Operation
- Digit map: index 3 = time_tens, 2 = time_ones, 1 = score_tens, 0 = score_ones; scan order 3→2→1→0→3.
- Dwell counter runs 0..DWELL-1. On wrap the index decrements, and 0 wraps to 3.
- Snapshot: all four inputs are registered together only at index==0 && counter==DWELL-1, i.e. at the end of the frame. The display never mixes digits from different input values. Snapshot reset value is all zeros.
- Decode of a digit value:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any value from 10 to 15 decodes to dash 0111111.
- Leading-zero blanking:
  - Index 3 shows 1111111 when snapshot time_tens==0.
  - Index 1 shows 1111111 when snapshot score_tens==0.
  - Ones digits always show.
- dp is 0 only while index 2 is active, as the time/score separator. Otherwise dp is 1.
- Guard: `an` is 1111 whenever counter==0, so every digit is dark for one cycle after each switch.
- Otherwise `an` is the active-low one-hot of the index, unless en==0 or the display is in blink-off.
- frame_done asserts on the cycle after index==0 && counter==DWELL-1.
- en==0:
  - an = 1111 and frame_done = 0.
  - Counters, index and snapshot hold.
  - Scanning resumes from the held state the cycle after en returns to 1.

## Timing
- an, seg, dp and frame_done are all registered. Each reflects the state of the previous cycle, one cycle of latency from the counter and index.
- Reset values:
  - an = 1111, seg = 1111111, dp = 1, frame_done = 0
  - index = 3, counter = 0, snapshot = 0, blink phase = on
- Reset asserted mid-frame takes effect at the next edge and overrides en.
- First frame after reset displays the zero snapshot: time shows "0" on index 2 and score shows "0" on index 0, both tens digits blanked.
- Input changes appear on the display one frame after the next snapshot edge.
- Frame length = 4·DWELL cycles.

## Configuration
- SEG7_BLINK_EN defined:
  - When snapshot time == 00, a frame counter toggles the blink phase every BLINK_FRAMES frames.
  - In the off phase, an = 1111 for whole frames.
  - When snapshot time ≠ 00, the frame counter clears and the phase is forced on.
- SEG7_BLINK_EN undefined: no blink logic; a 00 time displays steadily.

## Structure
- Package seg7_pkg holds:
  - the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK)
  - the digit-index localparams
  - the DWELL computation function
- Counter widths use $clog2 of DWELL and BLINK_FRAMES.
- Sub-module seg7_decode: combinational 4-bit BCD to 7-bit active-low segments. It takes a blank input and is instantiated once on the selected snapshot digit.

## Test plan
All scenarios use CLOCK_FREQ=8, REFRESH_HZ=2 (DWELL=4) and BLINK_FRAMES=2.
- Reset then time 4,5 and score 0,7 held steady:
  - Frame 1 shows zeros with tens blanked.
  - From frame 2: index 3 seg 0011001, index 2 seg 0010010 with dp=0, index 1 blank, index 0 seg 1111000.
  - frame_done pulses every 16 cycles.
- Guard check: `an` = 1111 on exactly one cycle after each index change. `an` is never more than one-hot-low.
- Change time_ones mid-frame from 5 to 4: the displayed value changes only in the frame after the snapshot edge, with no mixed frame.
- en low for 10 cycles mid-digit: an = 1111, no frame_done, and scanning resumes at the same index and counter.
- Score tens = 12: index 1 shows dash 0111111.
- SEG7_BLINK_EN with time 0,0: two frames on and two frames dark, alternating. Setting time to 1,0 restores a steady display at the next snapshot.
